dac_spi_serializer: RTL
=======================

Name: dac_spi_serializer

Overview:
- Downstream stage of the signal generator: consumes its signed interpolated sample bus and drives an external SPI DAC.
- Samples the input at a fixed rate set by an internal sample timer.
- Rounds and saturates each sample to DAC width, converts it to offset binary, and shifts it out MSB-first on a CS/SCLK/MOSI link.
- Flags sample ticks that are dropped because a frame is still in flight.

Parameters:
- IN_WIDTH, 24, width of signed input sample (generator DATA_SIZE+PRECISION).
- DAC_WIDTH, 12, DAC word width; 2 <= DAC_WIDTH < IN_WIDTH.
- CLK_DIV, 2, i_clk cycles per SCLK half-period; >= 1.
- SAMPLE_DIV, 64, i_clk cycles per sample period; must be >= CLK_DIV*(2*DAC_WIDTH+2).

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_res  in  1  reset, asynchronous, active-low.
- i_data  in  IN_WIDTH signed  sample from signal generator; only the value present on the tick cycle is used.
- i_en  in  1  enables sample timer.
- o_sclk  out  1  SPI clock, idle low; DAC samples MOSI on the rising edge.
- o_mosi  out  1  SPI data, MSB first.
- o_cs_n  out  1  DAC chip select, active-low.
- o_busy  out  1  high while a frame is in flight (cs_n low).
- o_sample  out  1  one-cycle pulse on the cycle a sample is captured.
- o_overrun  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset (i_res low, asynchronous):
  - Outputs: o_cs_n=1, o_sclk=0, o_mosi=0, o_busy=0, o_sample=0, o_overrun=0.
  - Internal: sample timer=0, FSM=IDLE.
  - Reset asserted mid-frame aborts the frame immediately.
- All outputs are registered.
- Sample timer:
  - While i_en=1, counts 0..SAMPLE_DIV-1 and wraps.
  - tick = (count==SAMPLE_DIV-1) && i_en.
  - While i_en=0, the timer is held at 0 and no ticks occur.
- Quantise (combinational, evaluated on the tick cycle):
  - Compute s = (i_data + 2^(IN_WIDTH-DAC_WIDTH-1)) >>> (IN_WIDTH-DAC_WIDTH) (round half up, arithmetic shift).
  - Compute the sum at IN_WIDTH+1 bits. If positive overflow, s = 2^(DAC_WIDTH-1)-1. Negative overflow is impossible.
  - Output word w = s with its MSB inverted (offset binary).
- FSM states IDLE, SETUP, SHIFT:
  - IDLE, tick -> SETUP:
    - w is latched into the shift register.
    - o_sample pulses on the tick cycle + 1.
    - o_cs_n=0, o_busy=1, o_mosi=w[MSB], all from tick + 1.
  - SETUP: lasts CLK_DIV cycles with sclk low, then -> SHIFT.
  - SHIFT, per bit:
    - o_sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
    - At the start of each low phase o_mosi advances to the next bit.
    - The bit counter counts DAC_WIDTH rising edges.
    - After the low phase of the last bit -> IDLE: o_cs_n=1, o_busy=0, o_mosi=0.
- Frame length: CLK_DIV*(2*DAC_WIDTH+1) cycles with cs_n low; with defaults, 50 cycles.
- The SAMPLE_DIV constraint guarantees at least CLK_DIV cycles of cs_n high between frames.
- Tick while FSM != IDLE:
  - The sample is dropped: no o_sample, no capture.
  - o_overrun is set to 1 and stays set until reset.
  - The current frame is unaffected.
- i_en falling mid-frame: the current frame completes; no further ticks.
- i_en rising: first tick occurs SAMPLE_DIV cycles later (timer starts from 0).
- i_data changing during a frame has no effect.

Decomposition:
- dac_pkg holds:
  - typedef enum {IDLE, SETUP, SHIFT} dac_state_t.
  - localparam function for frame length, used for an elaboration-time assertion against SAMPLE_DIV.
- One sub-module: dac_quantiser (combinational round/saturate/offset-binary, parameters IN_WIDTH, DAC_WIDTH), unit-tested standalone.

Test Plan:
- Defaults, i_data=24'h000800, i_en=1 -> first o_sample 65 cycles after i_en rise; 12 bits shifted = 12'h801; cs_n low for exactly 50 cycles; 12 sclk rising edges.
- i_data=24'h7FFFFF -> saturate, word 12'hFFF. i_data=24'h800000 -> word 12'h000. i_data=24'hFFF800 -> word 12'h800. i_data=24'h0007FF -> word 12'h800.
- SAMPLE_DIV=40 (violates constraint, bench overrides assertion) -> second tick during frame: o_overrun=1, no o_sample on that tick, o_overrun stays 1 afterwards.
- i_en dropped 10 cycles into a frame -> frame completes with all 12 bits, cs_n returns high, no further cs_n activity for 200 cycles.
- i_res asserted low mid-SHIFT -> same cycle (async): o_cs_n=1, o_sclk=0, o_mosi=0, o_busy=0; after release with i_en=1, next frame starts SAMPLE_DIV+1 cycles later.
- CLK_DIV=1, SAMPLE_DIV=26 -> back-to-back frames with exactly 1 cycle of cs_n high, no overrun over 10 frames.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and helpers for the SPI DAC serializer.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT
    } dac_state_t;

    // Cycles with cs_n low for one frame: setup phase plus two phases per bit.
    function automatic int unsigned frame_len(input int unsigned clk_div,
                                              input int unsigned dac_width);
        return clk_div * (2 * dac_width + 1);
    endfunction

endpackage

// File: rtl/dac_quantiser.sv
// Round-half-up, positive saturation and offset-binary conversion of a signed sample.
module dac_quantiser #(
    parameter int unsigned IN_WIDTH  = 24,
    parameter int unsigned DAC_WIDTH = 12
) (
    input  logic signed [IN_WIDTH-1:0]  i_data,
    output logic        [DAC_WIDTH-1:0] o_word
);

    localparam int unsigned SHIFT_BITS = IN_WIDTH - DAC_WIDTH;
    localparam logic [IN_WIDTH:0] HALF = (IN_WIDTH + 1)'(1) << (SHIFT_BITS - 1);

    logic [IN_WIDTH:0]    sum;
    logic [DAC_WIDTH:0]   shifted;
    logic [DAC_WIDTH-1:0] sat;

    // Sign-extend by one bit so the rounding add cannot wrap; the top DAC_WIDTH+1 bits
    // are the arithmetic right shift. Only positive overflow is reachable.
    always_comb begin
        sum     = {i_data[IN_WIDTH-1], i_data} + HALF;
        shifted = sum[IN_WIDTH -: DAC_WIDTH + 1];
        if (!shifted[DAC_WIDTH] && shifted[DAC_WIDTH-1]) begin
            sat = {1'b0, {(DAC_WIDTH - 1){1'b1}}};
        end else begin
            sat = shifted[DAC_WIDTH-1:0];
        end
        o_word = {~sat[DAC_WIDTH-1], sat[DAC_WIDTH-2:0]};
    end

endmodule

// File: rtl/dac_spi_serializer.sv
// Samples the generator output on a fixed timer and shifts it MSB-first to an SPI DAC.
module dac_spi_serializer
    import dac_pkg::*;
#(
    parameter int unsigned IN_WIDTH     = 24,
    parameter int unsigned DAC_WIDTH    = 12,
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned SAMPLE_DIV   = 64,
    parameter bit          TIMING_CHECK = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_res,
    input  logic signed [IN_WIDTH-1:0] i_data,
    input  logic                       i_en,
    output logic                       o_sclk,
    output logic                       o_mosi,
    output logic                       o_cs_n,
    output logic                       o_busy,
    output logic                       o_sample,
    output logic                       o_overrun
);

    localparam int unsigned TW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BW  = $clog2(DAC_WIDTH);

    // Guarantee at least CLK_DIV cycles of cs_n high between frames.
    if (TIMING_CHECK && (SAMPLE_DIV < frame_len(CLK_DIV, DAC_WIDTH) + CLK_DIV)) begin : g_bad_timing
        $error("SAMPLE_DIV too small for one frame plus CLK_DIV idle cycles");
    end

    dac_state_t           state_q, state_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic                 en_q;
    logic [DCW-1:0]       div_q, div_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DAC_WIDTH-1:0] shreg_q, shreg_d;
    logic                 sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
    logic                 busy_q, busy_d, sample_q, sample_d, overrun_q, overrun_d;
    logic                 tick, div_last;
    logic [DAC_WIDTH-1:0] word;

    dac_quantiser #(
        .IN_WIDTH (IN_WIDTH),
        .DAC_WIDTH(DAC_WIDTH)
    ) u_quant (
        .i_data(i_data),
        .o_word(word)
    );

    // Sample timer: restarts from 0 one cycle after i_en rises, held at 0 while disabled.
    always_comb begin
        tick  = en_q && i_en && (cnt_q == TW'(SAMPLE_DIV - 1));
        cnt_d = '0;
        if (en_q && i_en && !tick) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Timer state register.
    always_ff @(posedge i_clk or negedge i_res) begin
        if (!i_res) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= i_en;
        end
    end

    // Frame FSM next state and registered SPI outputs.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        sample_d  = 1'b0;
        overrun_d = overrun_q;
        div_last  = (div_q == DCW'(CLK_DIV - 1));

        if (tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d  = SETUP;
                    shreg_d  = word;
                    mosi_d   = word[DAC_WIDTH-1];
                    cs_n_d   = 1'b0;
                    busy_d   = 1'b1;
                    sample_d = 1'b1;
                    div_d    = '0;
                end
            end
            SETUP: begin
                if (div_last) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + DCW'(1);
                end
            end
            SHIFT: begin
                if (!div_last) begin
                    div_d = div_q + DCW'(1);
                end else begin
                    div_d = '0;
                    if (sclk_q) begin
                        // Falling edge: present the next bit for the following rise.
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[DAC_WIDTH-2:0], 1'b0};
                        mosi_d  = shreg_q[DAC_WIDTH-2];
                    end else if (bit_q == BW'(DAC_WIDTH - 1)) begin
                        state_d = IDLE;
                        cs_n_d  = 1'b1;
                        busy_d  = 1'b0;
                        mosi_d  = 1'b0;
                    end else begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame FSM and output registers.
    always_ff @(posedge i_clk or negedge i_res) begin
        if (!i_res) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            sample_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            sample_q  <= sample_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_sclk    = sclk_q;
    assign o_mosi    = mosi_q;
    assign o_cs_n    = cs_n_q;
    assign o_busy    = busy_q;
    assign o_sample  = sample_q;
    assign o_overrun = overrun_q;

endmodule
